loteria_arbitro: RTL and testbench

//  Round-robin arbiter/sequencer sharing one lottery checker (5-digit BCD entry, insert/finish strobes, win/prize result)

---
 rtl/loteria_arbitro.sv | 203 ++++++++++++++++++++
 tb/tb_loteria_arbitro.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loteria_arbitro.sv
// loteria_arbitro: round-robin sharing of one lottery checker among NPLAYERS terminals.
// Ports: clk, reset (async, active-low), req/ticket in, grant/ack/res_* out, chk_* checker link, games/wins counters.
module loteria_arbitro #(
  parameter int NPLAYERS = 4,
  parameter int CHK_LAT  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPLAYERS-1:0]      req,
  input  logic [NPLAYERS*20-1:0]   ticket,
  output logic [NPLAYERS-1:0]      grant,
  output logic [NPLAYERS-1:0]      ack,
  output logic                     res_win,
  output logic [1:0]               res_prize,
  output logic                     res_err,
  output logic                     busy,
  output logic                     chk_clear,
  output logic [3:0]               chk_num,
  output logic                     chk_insert,
  output logic                     chk_finish,
  input  logic                     chk_win,
  input  logic [1:0]               chk_prize,
  output logic [CNT_W-1:0]         games,
  output logic [CNT_W-1:0]         wins
);

  localparam int IW = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
  localparam int CW = $clog2(CHK_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD, FIN, WAIT, RESP
  } state_t;

  state_t             state, state_n;
  logic [IW-1:0]      rr, rr_n;
  logic [IW-1:0]      own, own_n;
  logic [2:0]         idx, idx_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [19:0]        tkt, tkt_n;
  logic [NPLAYERS-1:0] grant_n, ack_n;
  logic               res_win_n, res_err_n;
  logic [1:0]         res_prize_n;
  logic               busy_n, chk_clear_n;
  logic               chk_insert_n, chk_finish_n;
  logic [3:0]         chk_num_n;
  logic [CNT_W-1:0]   games_n, wins_n;
  logic               found, bad;
  int                 pick;

  // digit0 is the most significant nibble
  function automatic logic [3:0] digit(
    input logic [19:0] t,
    input int          i
  );
    return t[19-4*i -: 4];
  endfunction

  always_comb begin
    state_n      = state;
    rr_n         = rr;
    own_n        = own;
    idx_n        = idx;
    cnt_n        = cnt;
    tkt_n        = tkt;
    grant_n      = grant;
    ack_n        = '0;
    res_win_n    = res_win;
    res_prize_n  = res_prize;
    res_err_n    = res_err;
    chk_clear_n  = 1'b0;
    chk_insert_n = 1'b0;
    chk_finish_n = 1'b0;
    chk_num_n    = 4'd0;
    games_n      = games;
    wins_n       = wins;
    found        = 1'b0;
    pick         = 0;
    bad          = 1'b0;

    for (int d = 0; d < 5; d++) begin
      if (digit(tkt, d) > 4'd9) bad = 1'b1;
    end

    // first requester at or above rr, wrapping
    for (int off = 0; off < NPLAYERS; off++) begin
      int j;
      j = int'(rr) + off;
      if (j >= NPLAYERS) j = j - NPLAYERS;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end

    unique case (state)
      IDLE: begin
        if (found) begin
          state_n       = CLR;
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          own_n         = IW'(pick);
          tkt_n         = ticket[20*pick +: 20];
          chk_clear_n   = 1'b1;
          res_win_n     = 1'b0;
          res_prize_n   = 2'b00;
          res_err_n     = 1'b0;
        end
      end
      CLR: begin
        if (bad) begin
          res_err_n = 1'b1;
          ack_n     = grant;
          state_n   = RESP;
        end else begin
          state_n      = LOAD;
          idx_n        = 3'd0;
          chk_insert_n = 1'b1;
          chk_num_n    = digit(tkt, 0);
        end
      end
      LOAD: begin
        if (idx == 3'd4) begin
          state_n      = FIN;
          chk_finish_n = 1'b1;
        end else begin
          idx_n        = idx + 3'd1;
          chk_insert_n = 1'b1;
          chk_num_n    = digit(tkt, int'(idx) + 1);
        end
      end
      FIN: begin
        state_n = WAIT;
        cnt_n   = CW'(CHK_LAT);
      end
      WAIT: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          res_win_n   = chk_win;
          res_prize_n = chk_prize;
          ack_n       = grant;
          state_n     = RESP;
        end
      end
      RESP: begin
        grant_n = '0;
        idx_n   = 3'd0;
        state_n = IDLE;
        rr_n    = (own == IW'(NPLAYERS-1)) ? '0 : own + IW'(1);
        if (!res_err) begin
          if (games != '1) games_n = games + CNT_W'(1);
          if (res_win && wins != '1) wins_n = wins + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr         <= '0;
      own        <= '0;
      idx        <= 3'd0;
      cnt        <= '0;
      tkt        <= '0;
      grant      <= '0;
      ack        <= '0;
      res_win    <= 1'b0;
      res_prize  <= 2'b00;
      res_err    <= 1'b0;
      busy       <= 1'b0;
      chk_clear  <= 1'b0;
      chk_insert <= 1'b0;
      chk_finish <= 1'b0;
      chk_num    <= 4'd0;
      games      <= '0;
      wins       <= '0;
    end else begin
      state      <= state_n;
      rr         <= rr_n;
      own        <= own_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      tkt        <= tkt_n;
      grant      <= grant_n;
      ack        <= ack_n;
      res_win    <= res_win_n;
      res_prize  <= res_prize_n;
      res_err    <= res_err_n;
      busy       <= busy_n;
      chk_clear  <= chk_clear_n;
      chk_insert <= chk_insert_n;
      chk_finish <= chk_finish_n;
      chk_num    <= chk_num_n;
      games      <= games_n;
      wins       <= wins_n;
    end
  end

endmodule

// File: tb/tb_loteria_arbitro.sv
// tb_loteria_arbitro: scoreboard bench for loteria_arbitro.
// Two instances: (CHK_LAT=3, CNT_W=16) and (CHK_LAT=1, CNT_W=2), each with its own checker model.
module tb_loteria_arbitro;

  localparam int NP = 4;

  typedef struct {
    int         p;
    logic       win;
    logic [1:0] prz;
    logic       err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [79:0] ticket;
  logic [3:0]  req_v[2];
  logic [3:0]  grant_v[2];
  logic [3:0]  ack_v[2];
  logic        rwin_v[2];
  logic [1:0]  rprz_v[2];
  logic        rerr_v[2];
  logic        busy_v[2];
  logic        clr_v[2];
  logic [3:0]  num_v[2];
  logic        ins_v[2];
  logic        fin_v[2];
  logic        cwin_v[2];
  logic [1:0]  cprz_v[2];
  logic [15:0] games0, wins0;
  logic [1:0]  games1, wins1;

  exp_t q0[$];
  exp_t q1[$];
  int   ncmp = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   rr_m = 0;

  logic [19:0] dig[2];
  int          nins[2];
  int          fc[2];
  int          t0[2];
  bit          fins[2];
  bit          cntchk[2];
  int          mg[2];
  int          mw[2];

  loteria_arbitro #(.NPLAYERS(4), .CHK_LAT(3), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .ticket(ticket),
    .grant(grant_v[0]), .ack(ack_v[0]), .res_win(rwin_v[0]),
    .res_prize(rprz_v[0]), .res_err(rerr_v[0]), .busy(busy_v[0]),
    .chk_clear(clr_v[0]), .chk_num(num_v[0]), .chk_insert(ins_v[0]),
    .chk_finish(fin_v[0]), .chk_win(cwin_v[0]), .chk_prize(cprz_v[0]),
    .games(games0), .wins(wins0)
  );

  loteria_arbitro #(.NPLAYERS(4), .CHK_LAT(1), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .ticket(ticket),
    .grant(grant_v[1]), .ack(ack_v[1]), .res_win(rwin_v[1]),
    .res_prize(rprz_v[1]), .res_err(rerr_v[1]), .busy(busy_v[1]),
    .chk_clear(clr_v[1]), .chk_num(num_v[1]), .chk_insert(ins_v[1]),
    .chk_finish(fin_v[1]), .chk_win(cwin_v[1]), .chk_prize(cprz_v[1]),
    .games(games1), .wins(wins1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int g, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL u%0d %s: got %0h want %0h", g, nm, act, exp);
    end
  endtask

  // checker behaviour: full match 50967 -> prize 01, last three 967 -> prize 10
  function automatic logic [2:0] rule(input logic [19:0] d);
    if (d == 20'h50967) return 3'b101;
    if (d[11:0] == 12'h967) return 3'b110;
    return 3'b000;
  endfunction

  function automatic logic is_bad(input logic [19:0] t);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 5; i++) if (t[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [3:0] rd();
    return 4'($urandom_range(0, 9));
  endfunction

  function automatic logic [19:0] rand_ticket();
    logic [19:0] t;
    int          k;
    t = {rd(), rd(), rd(), rd(), rd()};
    k = $urandom_range(0, 9);
    if (k < 2) t = 20'h50967;
    else if (k < 4) t = {rd(), rd(), 12'h967};
    else if (k == 4) t[4*$urandom_range(0, 4) +: 4] = 4'($urandom_range(10, 15));
    return t;
  endfunction

  // checker models and response monitor
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int          lat, mx, ns;
      logic [31:0] gm, wn;
      exp_t        e;
      logic [2:0]  r;
      lat = (g == 0) ? 3 : 1;
      mx  = (g == 0) ? 65535 : 3;
      gm  = (g == 0) ? 32'(games0) : 32'(games1);
      wn  = (g == 0) ? 32'(wins0) : 32'(wins1);
      if (!reset) begin
        nins[g] = 0; fins[g] = 1'b0; cntchk[g] = 1'b0;
        mg[g] = 0; mw[g] = 0;
        cwin_v[g] = 1'b0; cprz_v[g] = 2'b00;
      end else begin
        if (clr_v[g]) begin
          dig[g] = '0; nins[g] = 0; fins[g] = 1'b0; t0[g] = cyc;
        end
        if (ins_v[g]) begin
          dig[g] = {dig[g][15:0], num_v[g]};
          nins[g]++;
        end
        if (fin_v[g]) begin
          fins[g] = 1'b1; fc[g] = cyc;
        end
        ns = int'(clr_v[g]) + int'(ins_v[g]) + int'(fin_v[g]);
        if (ns != 0) chk(g, "strobe_excl", 32'(ns <= 1), 32'd1);
        r = (fins[g] && cyc >= fc[g] + lat) ? rule(dig[g]) : 3'b000;
        cwin_v[g] = r[2];
        cprz_v[g] = r[1:0];

        if (cntchk[g]) begin
          chk(g, "games", gm, 32'(mg[g]));
          chk(g, "wins", wn, 32'(mw[g]));
          cntchk[g] = 1'b0;
        end
        if (ack_v[g] != 4'b0000) begin
          if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
            chk(g, "unexpected_ack", 32'(ack_v[g]), 32'd0);
          end else begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            chk(g, "ack", 32'(ack_v[g]), 32'(4'b0001 << e.p));
            chk(g, "grant", 32'(grant_v[g]), 32'(4'b0001 << e.p));
            chk(g, "res_win", 32'(rwin_v[g]), 32'(e.win));
            chk(g, "res_prize", 32'(rprz_v[g]), 32'(e.prz));
            chk(g, "res_err", 32'(rerr_v[g]), 32'(e.err));
            chk(g, "latency", 32'(cyc - t0[g]), 32'(e.err ? 1 : 7 + lat));
            chk(g, "strobes", 32'({nins[g][7:0], 7'd0, fins[g]}),
                e.err ? 32'd0 : 32'h0501);
            if (!e.err) begin
              if (mg[g] < mx) mg[g]++;
              if (e.win && mw[g] < mx) mw[g]++;
            end
            cntchk[g] = 1'b1;
          end
        end
      end
    end
  end

  // terminals drop req on the cycle they see ack
  task automatic step();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < NP; i++) if (ack_v[g][i]) req_v[g][i] = 1'b0;
    end
  endtask

  task automatic chk_zero(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk(g, nm, 32'({grant_v[g], ack_v[g], rwin_v[g], rprz_v[g], rerr_v[g],
                      busy_v[g], clr_v[g], num_v[g], ins_v[g], fin_v[g]}), 32'd0);
    end
    chk(0, {nm, "_cnt"}, {games0, wins0}, 32'd0);
    chk(1, {nm, "_cnt"}, 32'({games1, wins1}), 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      step();
      n++;
    end
    chk(0, "done_timeout", 32'(q0.size() + q1.size()), 32'd0);
    q0.delete();
    q1.delete();
    step();
    step();
  endtask

  task automatic expect_p(input int p, input logic [19:0] tk);
    exp_t       e;
    logic [2:0] r;
    e.p   = p;
    e.err = is_bad(tk);
    r     = e.err ? 3'b000 : rule(tk);
    e.win = r[2];
    e.prz = r[1:0];
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // all requests of a round rise together, so service is a rotation from rr
  task automatic play(input logic [3:0] m, input logic [79:0] t);
    int p, last;
    last   = rr_m;
    ticket = t;
    req_v[0] = m;
    req_v[1] = m;
    for (int off = 0; off < NP; off++) begin
      p = (rr_m + off) % NP;
      if (m[p]) begin
        expect_p(p, t[20*p +: 20]);
        last = p;
      end
    end
    rr_m = (last + 1) % NP;
    wait_done();
  endtask

  initial begin
    int k, n;
    logic [3:0] m;
    reset    = 1'b1;
    ticket   = '0;
    req_v[0] = '0;
    req_v[1] = '0;
    step();
    reset = 1'b0;
    step();
    step();
    chk_zero("reset_state");
    reset = 1'b1;
    step();

    play(4'hF, {rand_ticket(), 20'h5A967, 20'h12345, 20'h50967});
    play(4'h1, {60'h0, 20'h50967});
    play(4'h2, {40'h0, 20'h12345, 20'h0});
    play(4'h4, {20'h0, 20'h5A967, 40'h0});
    repeat (40) begin
      m = 4'($urandom_range(1, 15));
      play(m, {rand_ticket(), rand_ticket(), rand_ticket(), rand_ticket()});
    end

    ticket   = {60'h0, 20'h50967};
    req_v[0] = 4'h1;
    req_v[1] = 4'h1;
    k = 0;
    n = 0;
    while (k < 3 && n < 50) begin
      step();
      if (ins_v[0]) k++;
      n++;
    end
    chk(0, "reset_wait", 32'(k), 32'd3);
    reset = 1'b0;
    #1;
    chk_zero("reset_midgame");
    q0.delete();
    q1.delete();
    rr_m = 0;
    step();
    step();
    reset = 1'b1;
    expect_p(0, 20'h50967);
    rr_m = 1;
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
